// File: rtl/router_input_fifo.sv
// router_input_fifo: per-port input buffer of the mesh router.
// RTS/CTS write side, first-word fall-through head, pop on any arbiter grant.
`default_nettype none

module router_input_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        RX,
  input  logic                         DRTS,
  output logic                         CTS,
  input  logic                         read_en_N,
  input  logic                         read_en_E,
  input  logic                         read_en_W,
  input  logic                         read_en_S,
  input  logic                         read_en_L,
  output logic [DATA_WIDTH-1:0]        Data_out,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         multi_read_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  cts_q, cts_d;
  logic                  err_q, err_d;

  logic                  write_en;
  logic                  read_do;
  logic                  any_rd;
  logic [2:0]            num_rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  assign any_rd = read_en_N | read_en_E | read_en_W | read_en_S | read_en_L;
  assign num_rd = {2'b00, read_en_N} + {2'b00, read_en_E} + {2'b00, read_en_W}
                + {2'b00, read_en_S} + {2'b00, read_en_L};

  // Full is judged on the pre-pop occupancy, so a pop never frees a slot in the same cycle.
  assign write_en = DRTS & ~cts_q & ~full;
  assign read_do  = any_rd & ~empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    cts_d    = write_en;
    err_d    = err_q | (num_rd > 3'd1);
    if (write_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (read_do)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({write_en, read_do})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      cts_q    <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      cts_q    <= cts_d;
      err_q    <= err_d;
      if (write_en) mem_q[wr_ptr_q] <= RX;
    end
  end

  assign CTS            = cts_q;
  assign Data_out       = mem_q[rd_ptr_q];
  assign count          = count_q;
  assign multi_read_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_router_input_fifo.sv
// Directed self-checking bench for router_input_fifo (DATA_WIDTH=32, DEPTH=4).
`default_nettype none

module tb_router_input_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] RX;
  logic        DRTS;
  logic        CTS;
  logic        read_en_N, read_en_E, read_en_W, read_en_S, read_en_L;
  logic [31:0] Data_out;
  logic        empty, full;
  logic [2:0]  count;
  logic        multi_read_err;

  int tests = 0;
  int fails = 0;

  router_input_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .RX(RX), .DRTS(DRTS), .CTS(CTS),
    .read_en_N(read_en_N), .read_en_E(read_en_E), .read_en_W(read_en_W),
    .read_en_S(read_en_S), .read_en_L(read_en_L),
    .Data_out(Data_out), .empty(empty), .full(full), .count(count),
    .multi_read_err(multi_read_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_rd();
    read_en_N = 0; read_en_E = 0; read_en_W = 0; read_en_S = 0; read_en_L = 0;
  endtask

  initial begin
    rst = 1; DRTS = 0; RX = '0; idle_rd();
    step(); step();
    rst = 0;
    check("rst_cts",   32'(CTS), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full",  32'(full), 0);
    check("rst_count", 32'(count), 0);
    check("rst_data",  Data_out, 0);
    check("rst_err",   32'(multi_read_err), 0);

    // single transfer
    DRTS = 1; RX = 32'hA5A5_0001;
    step();
    DRTS = 0;
    check("single_cts",   32'(CTS), 1);
    check("single_empty", 32'(empty), 0);
    check("single_count", 32'(count), 1);
    check("single_data",  Data_out, 32'hA5A5_0001);
    step();
    check("single_cts_drop", 32'(CTS), 0);
    read_en_E = 1;
    step();
    read_en_E = 0;
    check("single_pop_empty", 32'(empty), 1);
    check("single_pop_count", 32'(count), 0);

    // fill to full: each flit takes a write edge plus a CTS gap edge
    DRTS = 1;
    for (int i = 1; i <= 4; i++) begin
      RX = 32'(i);
      step();
      check("fill_cts_hi", 32'(CTS), 1);
      check("fill_count",  32'(count), 32'(i));
      step();
      check("fill_cts_lo", 32'(CTS), 0);
    end
    RX = 32'd5;
    step();
    check("full_block_cts", 32'(CTS), 0);
    step();
    check("full_block_cts2", 32'(CTS), 0);
    check("full_count", 32'(count), 4);
    check("full_flag",  32'(full), 1);
    check("full_head",  Data_out, 1);

    // pop at full with DRTS high: write blocked this cycle, accepted next
    read_en_L = 1;
    step();
    read_en_L = 0;
    check("fullrd_cts",   32'(CTS), 0);
    check("fullrd_count", 32'(count), 3);
    check("fullrd_head",  Data_out, 2);
    step();
    DRTS = 0;
    check("fullrd_wr_cts",   32'(CTS), 1);
    check("fullrd_wr_count", 32'(count), 4);
    for (int k = 2; k <= 5; k++) begin
      check("drain_order", Data_out, 32'(k));
      read_en_N = 1;
      step();
    end
    read_en_N = 0;
    check("drain_empty", 32'(empty), 1);
    check("drain_count", 32'(count), 0);

    // read while empty
    read_en_W = 1;
    step();
    read_en_W = 0;
    check("rd_empty_count", 32'(count), 0);
    check("rd_empty_err",   32'(multi_read_err), 0);

    // preload two flits, then simultaneous push/pop across the pointer wrap
    DRTS = 1; RX = 32'h10; step(); step();
    RX = 32'h11; step(); step();
    check("pre_count", 32'(count), 2);
    check("pre_head",  Data_out, 32'h10);
    for (int k = 0; k < 5; k++) begin
      RX = 32'h20 + 32'(k); DRTS = 1; read_en_S = 1;
      step();
      DRTS = 0; read_en_S = 0;
      check("wrap_count", 32'(count), 2);
      check("wrap_cts",   32'(CTS), 1);
      check("wrap_head",  Data_out, (k == 0) ? 32'h11 : 32'h20 + 32'(k - 1));
      step();
      check("wrap_idle_count", 32'(count), 2);
    end

    // multi-grant at count 3
    DRTS = 1; RX = 32'h30; step(); step(); DRTS = 0;
    check("mg_pre_count", 32'(count), 3);
    check("mg_pre_head",  Data_out, 32'h23);
    read_en_N = 1; read_en_S = 1;
    step();
    idle_rd();
    check("mg_count", 32'(count), 2);
    check("mg_err",   32'(multi_read_err), 1);
    check("mg_head",  Data_out, 32'h24);
    step();
    check("mg_err_sticky", 32'(multi_read_err), 1);

    // reset mid-operation with a pending flit
    DRTS = 1; RX = 32'h55; rst = 1;
    step();
    rst = 0; DRTS = 0;
    check("mrst_cts",   32'(CTS), 0);
    check("mrst_count", 32'(count), 0);
    check("mrst_empty", 32'(empty), 1);
    check("mrst_full",  32'(full), 0);
    check("mrst_data",  Data_out, 0);
    check("mrst_err",   32'(multi_read_err), 0);
    step();
    check("mrst_not_stored", 32'(count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
